// File: rtl/mux_pipe_pkg.sv
// Shared limits, stage-action encoding and parameter legality check for module_mux_pipe.
// Latency: none. Backpressure: none (definitions only).
package mux_pipe_pkg;

  localparam int LAT_MAX   = 4;
  localparam int N_IN_MAX  = 16;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_FLUSH   = 2'd2
  } stage_act_e;

  // Flush beats stall; reset is handled by the register itself.
  function automatic stage_act_e stage_action(input logic flush, input logic stall);
    if (flush)      return ACT_FLUSH;
    else if (stall) return ACT_HOLD;
    else            return ACT_ADVANCE;
  endfunction

  function automatic bit params_ok(input int n_in, input int lat, input int sel_w);
    return (n_in >= 2) && (n_in <= N_IN_MAX) &&
           (lat >= 1) && (lat <= LAT_MAX) &&
           (sel_w == $clog2(n_in));
  endfunction

endpackage

// File: rtl/module_pipe_stage.sv
// One {data, valid} pipeline register with flush, stall and async reset.
// Latency: 1 cycle. Backpressure: stall_i holds the register.
module module_pipe_stage
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o,
  output logic             valid_o
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    unique case (stage_action(flush_i, stall_i))
      ACT_FLUSH:   q_d = '0;
      ACT_ADVANCE: q_d = '{valid: valid_i, data: d_i};
      default:     q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign d_o     = q_q.data;
  assign valid_o = q_q.valid;

endmodule

// File: rtl/module_mux_pipe.sv
// N_IN:1 select mux staged through LAT {data,valid} registers; stall holds, flush kills, sticky out-of-range flag.
// Optional saturating error counter on err_cnt_o when MUX_PIPE_ERR_CNT_EN is defined.
module module_mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 3,
  parameter int LAT   = 1,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [SEL_W-1:0]      s_i,
  input  logic [N_IN*WIDTH-1:0] d_i,
  output logic [WIDTH-1:0]      y_o,
  output logic                  valid_o,
  output logic                  sel_err_o
`ifdef MUX_PIPE_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
`endif
);

  if (!params_ok(N_IN, LAT, SEL_W)) begin : g_bad_params
    $error("module_mux_pipe: illegal N_IN/LAT/SEL_W");
  end

  logic [WIDTH-1:0] sel_d;
  logic             sel_oor;
  logic             err_set;
  logic             sel_err_q, sel_err_d;

  // Loop-based select keeps out-of-range codes from indexing past d_i.
  always_comb begin
    sel_d = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (32'(s_i) == 32'(k)) sel_d = d_i[k*WIDTH +: WIDTH];
    end
  end

  assign sel_oor   = 32'(s_i) >= 32'(N_IN);
  assign err_set   = valid_i && sel_oor && !flush_i && !stall_i;
  assign sel_err_d = sel_err_q | err_set;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err_o = sel_err_q;

`ifdef MUX_PIPE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_set && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  logic [WIDTH-1:0] chain_dat [0:LAT];
  logic             chain_vld [0:LAT];

  assign chain_dat[0] = sel_d;
  assign chain_vld[0] = valid_i;

  for (genvar g = 0; g < LAT; g++) begin : g_stage
    module_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .valid_i (chain_vld[g]),
      .d_i     (chain_dat[g]),
      .d_o     (chain_dat[g+1]),
      .valid_o (chain_vld[g+1])
    );
  end

  assign y_o     = chain_dat[LAT];
  assign valid_o = chain_vld[LAT];

endmodule

// File: tb/tb_module_mux_pipe.sv
// Two instances (N_IN=3/LAT=3 and N_IN=5/LAT=1) driven by directed and random stimulus, checked against
// a history-queue reference model.
module tb_module_mux_pipe;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int NA    = 3;
  localparam int NB    = 5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  s_a = '0;
  logic [2:0]  s_b = '0;
  logic [31:0] da [NA];
  logic [31:0] db [NB];
  logic [NA*32-1:0] d_a;
  logic [NB*32-1:0] d_b;
  logic [31:0] y_a, y_b;
  logic        valid_a, valid_b, err_a, err_b;
`ifdef MUX_PIPE_ERR_CNT_EN
  logic [7:0]  cnt_a, cnt_b;
`endif

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int k = 0; k < NA; k++) d_a[k*32 +: 32] = da[k];
    for (int k = 0; k < NB; k++) d_b[k*32 +: 32] = db[k];
  end

  module_mux_pipe #(.WIDTH(32), .N_IN(NA), .LAT(LAT_A)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .s_i(s_a), .d_i(d_a), .y_o(y_a), .valid_o(valid_a), .sel_err_o(err_a)
`ifdef MUX_PIPE_ERR_CNT_EN
    , .err_cnt_o(cnt_a)
`endif
  );

  module_mux_pipe #(.WIDTH(32), .N_IN(NB), .LAT(LAT_B)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .s_i(s_b), .d_i(d_b), .y_o(y_b), .valid_o(valid_b), .sel_err_o(err_b)
`ifdef MUX_PIPE_ERR_CNT_EN
    , .err_cnt_o(cnt_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: every advancing edge appends one {data,valid}; a flush appends LAT empty entries.
  // The output is the entry LAT positions back from the newest.
  typedef struct { logic [31:0] d; logic v; } ent_t;
  ent_t hist_a [$];
  ent_t hist_b [$];
  logic m_err_a, m_err_b;
  int   m_cnt_a, m_cnt_b;

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    repeat (LAT_A) hist_a.push_back('{32'd0, 1'b0});
    repeat (LAT_B) hist_b.push_back('{32'd0, 1'b0});
    m_err_a = 1'b0; m_err_b = 1'b0;
    m_cnt_a = 0;    m_cnt_b = 0;
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_y_a"},   y_a,            hist_a[hist_a.size()-LAT_A].d);
    check({ph, "_vld_a"}, 32'(valid_a),   32'(hist_a[hist_a.size()-LAT_A].v));
    check({ph, "_err_a"}, 32'(err_a),     32'(m_err_a));
    check({ph, "_y_b"},   y_b,            hist_b[hist_b.size()-LAT_B].d);
    check({ph, "_vld_b"}, 32'(valid_b),   32'(hist_b[hist_b.size()-LAT_B].v));
    check({ph, "_err_b"}, 32'(err_b),     32'(m_err_b));
`ifdef MUX_PIPE_ERR_CNT_EN
    check({ph, "_cnt_a"}, 32'(cnt_a),     32'(m_cnt_a));
    check({ph, "_cnt_b"}, 32'(cnt_b),     32'(m_cnt_b));
`endif
  endtask

  // One clock edge: update the model with the inputs that were sampled, then compare.
  task automatic tick(input string ph);
    logic [31:0] ea, eb;
    @(posedge clk_i);
    #1;
    ea = (int'(s_a) < NA) ? da[s_a] : 32'd0;
    eb = (int'(s_b) < NB) ? db[s_b] : 32'd0;
    if (flush_i) begin
      repeat (LAT_A) hist_a.push_back('{32'd0, 1'b0});
      repeat (LAT_B) hist_b.push_back('{32'd0, 1'b0});
    end else if (!stall_i) begin
      hist_a.push_back('{ea, valid_i});
      hist_b.push_back('{eb, valid_i});
      if (valid_i && int'(s_a) >= NA) begin m_err_a = 1'b1; if (m_cnt_a < 255) m_cnt_a++; end
      if (valid_i && int'(s_b) >= NB) begin m_err_b = 1'b1; if (m_cnt_b < 255) m_cnt_b++; end
    end
    while (hist_a.size() > 16) void'(hist_a.pop_front());
    while (hist_b.size() > 16) void'(hist_b.pop_front());
    compare_all(ph);
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    s_a = '0; s_b = '0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic randomize_inputs();
    flush_i = ($urandom_range(0, 19) == 0);
    stall_i = ($urandom_range(0, 4) == 0);
    valid_i = ($urandom_range(0, 9) < 7);
    s_a = 2'($urandom_range(0, 3));
    s_b = 3'($urandom_range(0, 7));
    for (int k = 0; k < NA; k++) da[k] = $urandom;
    for (int k = 0; k < NB; k++) db[k] = $urandom;
  endtask

  initial begin
    for (int k = 0; k < NA; k++) da[k] = 32'd0;
    for (int k = 0; k < NB; k++) db[k] = 32'd0;
    do_reset();
    #1;
    compare_all("reset");

    // Single operand through the LAT=1 instance.
    db[2] = 32'hCAFE0002; s_b = 3'd2; valid_i = 1'b1;
    da[0] = 32'h10; da[1] = 32'h20; da[2] = 32'h30; s_a = 2'd0;
    tick("t1");
    check("t1_y_b_const", y_b, 32'hCAFE0002);
    check("t1_vld_b_const", 32'(valid_b), 32'd1);

    // Stream 0,1,2 through LAT=3 with a two-cycle stall mid-stream.
    s_a = 2'd1; tick("t2");
    s_a = 2'd2; tick("t2");
    valid_i = 1'b0; s_a = 2'd0;
    check("t2_y_c3", y_a, 32'h10);
    tick("t2");
    check("t2_y_c4", y_a, 32'h20);
    stall_i = 1'b1;
    tick("t2s");
    tick("t2s");
    check("t2_y_hold", y_a, 32'h20);
    stall_i = 1'b0;
    tick("t2");
    check("t2_y_c5", y_a, 32'h30);

    // Flush together with stall clears operands in flight.
    valid_i = 1'b1; s_a = 2'd1; tick("t3");
    s_a = 2'd2; tick("t3");
    flush_i = 1'b1; stall_i = 1'b1; tick("t3f");
    check("t3_vld_flush", 32'(valid_a), 32'd0);
    check("t3_y_flush", y_a, 32'd0);
    flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b1; s_a = 2'd0; da[0] = 32'h55;
    tick("t3");
    valid_i = 1'b0;
    tick("t3");
    tick("t3");
    check("t3_new_op", y_a, 32'h55);

    // Out-of-range select sets a sticky flag.
    s_a = 2'd3; valid_i = 1'b1; s_b = 3'd0;
    tick("t4");
    for (int i = 0; i < 10; i++) begin
      s_a = 2'($urandom_range(0, 2)); valid_i = 1'b1;
      tick("t4");
    end
    check("t4_sticky", 32'(err_a), 32'd1);
    do_reset();
    s_a = 2'd3; valid_i = 1'b0;
    tick("t4n");
    tick("t4n");
    check("t4_no_flag", 32'(err_a), 32'd0);

    // Asynchronous reset with every stage full.
    valid_i = 1'b1; s_a = 2'd1; s_b = 3'd6; da[1] = 32'hA5A5_0001;
    repeat (4) tick("t5");
    #2;
    rst_i = 1'b1;
    #1;
    check("t5_async_y",   y_a, 32'd0);
    check("t5_async_vld", 32'(valid_a), 32'd0);
    check("t5_async_err", 32'(err_b), 32'd0);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      tick("rnd");
    end

`ifdef MUX_PIPE_ERR_CNT_EN
    // Counter saturation; flush and stall leave it alone.
    do_reset();
    flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b1; s_a = 2'd3; s_b = 3'd0;
    for (int i = 0; i < 300; i++) tick("t6");
    check("t6_sat", 32'(cnt_a), 32'd255);
    flush_i = 1'b1; tick("t6");
    flush_i = 1'b0; stall_i = 1'b1; tick("t6");
    stall_i = 1'b0; valid_i = 1'b0;
    tick("t6");
    check("t6_hold", 32'(cnt_a), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
